// File: rtl/typewriter_pkg.sv
// Shared types and constants for the typewriter feeder.
// Optional macro used by the feeder: TYPEWRITER_FEEDER_DOT_MERGE_EN.
package typewriter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP
    } feeder_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/typewriter_feeder_sync_fifo.sv
// Power-of-two synchronous FIFO with single or double pop and a head+1 peek.
// Pointers carry one extra wrap bit so level is a plain subtraction.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    input  logic                     i_pop2,
    output logic [DATA_W-1:0]        o_head,
    output logic [DATA_W-1:0]        o_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [AW-1:0]     w_rd_idx;
    logic [AW-1:0]     w_nx_idx;
    logic [PW-1:0]     w_rd_step;

    assign w_rd_idx  = r_rd[AW-1:0];
    assign w_nx_idx  = w_rd_idx + AW'(1);
    assign w_rd_step = PW'(i_pop) + PW'(i_pop2);

    assign o_head  = r_mem[w_rd_idx];
    assign o_next  = r_mem[w_nx_idx];
    assign o_level = r_wr - r_rd;
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (o_level == PW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + PW'(1);
            end
            r_rd <= r_rd + w_rd_step;
        end
    end

endmodule

// File: rtl/typewriter_feeder.sv
// Paces buffered ASCII bytes onto the typewriter char/dp/shift inputs.
// Define TYPEWRITER_FEEDER_DOT_MERGE_EN to fold a following '.' into out_dp.
module typewriter_feeder
    import typewriter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int GAP_CYCLES   = 100000,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_char,
    output logic                          in_ready,
    output logic [7:0]                    out_char,
    output logic                          out_dp,
    output logic                          out_shift,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(max_int(GAP_CYCLES, PULSE_CYCLES) + 1);

    feeder_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_char;
    logic              r_dp;
    logic              r_shift;

    logic              w_push;
    logic              w_pop;
    logic              w_merge;
    logic [7:0]        w_head;
    logic [7:0]        w_next;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;

    assign w_push = in_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty;

`ifdef TYPEWRITER_FEEDER_DOT_MERGE_EN
    // Only a non-dot head may absorb the dot behind it; the dot must already be stored.
    assign w_merge = w_pop && (w_head != ASCII_DOT) && (w_next == ASCII_DOT)
                     && (w_level >= LVL_W'(2));
`else
    logic w_unused_next;
    assign w_unused_next = ^w_next;
    assign w_merge       = 1'b0;
`endif

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_wdata (in_char),
        .i_pop   (w_pop),
        .i_pop2  (w_merge),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_char  <= ASCII_SPACE;
            r_dp    <= 1'b0;
            r_shift <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_char  <= w_head;
                        r_dp    <= w_merge;
                        r_cnt   <= '0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_shift <= 1'b1;
                    r_cnt   <= CNT_W'(PULSE_CYCLES - 1);
                    r_state <= PULSE;
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_shift <= 1'b0;
                        r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign out_char  = r_char;
    assign out_dp    = r_dp;
    assign out_shift = r_shift;
    assign busy      = (r_state != IDLE) || !w_empty;
    assign level     = w_level;

endmodule
